// File: rtl/nn_layer_mac_engine_pkg.sv
// Shared definitions for the single-layer MAC engine.
//   - FSM state codes (plain 3-bit constants, legacy-compatible)
//   - request mode codes
//   - sat_dw: clamp a signed integer to a dw-bit two's-complement range
//   - idx_w : index width for a count of n items (never below 1)
package nn_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FWD_MAC = 3'd1;
    localparam logic [2:0] S_FWD_OUT = 3'd2;
    localparam logic [2:0] S_WAIT_BP = 3'd3;
    localparam logic [2:0] S_BP_MAC  = 3'd4;
    localparam logic [2:0] S_BP_OUT  = 3'd5;
    localparam logic [2:0] S_UPDATE  = 3'd6;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_BP  = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sat_dw(input int v, input int dw);
        int hi;
        int lo;
        hi = (1 <<< (dw - 1)) - 1;
        lo = -(1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/nn_layer_mac_engine_if.sv
// Bus bundle for nn_layer_mac_engine.
//   input side : in_valid/in_ready handshake, in_mode, in_last_layer, in_data
//   output side: out_valid/out_ready handshake, out_kind, out_data
//   weight load: w_we, w_addr (row*N+col), w_data
//   status     : busy
// master = the client driving requests; slave = the engine.
interface nn_layer_mac_engine_if #(
    parameter int N  = 9,
    parameter int DW = 7
);
    localparam int WA = nn_pkg::idx_w(N * N);

    logic            in_valid;
    logic            in_ready;
    logic            in_mode;
    logic            in_last_layer;
    logic [N*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_kind;
    logic [N*DW-1:0] out_data;
    logic            w_we;
    logic [WA-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            busy;

    modport master (
        output in_valid, in_mode, in_last_layer, in_data, out_ready,
               w_we, w_addr, w_data,
        input  in_ready, out_valid, out_kind, out_data, busy
    );

    modport slave (
        input  in_valid, in_mode, in_last_layer, in_data, out_ready,
               w_we, w_addr, w_data,
        output in_ready, out_valid, out_kind, out_data, busy
    );
endinterface

// File: rtl/nn_layer_mac_engine_mac_sat.sv
// nn_mac_sat: signed multiply-accumulate with a final shift + saturate.
//   clk, reset : clock, synchronous active-high reset
//   en         : accumulate this cycle
//   first      : discard the running sum (start of a new dot product)
//   a, b       : signed DW-bit operands
//   res        : sat_DW((sum including the current product) >>> SHIFT)
// res is combinational so the caller can capture a finished dot product on
// the same cycle its last product arrives.
module nn_mac_sat
    import nn_pkg::*;
#(
    parameter int DW    = 7,
    parameter int AW    = 18,
    parameter int SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 first,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] res
);
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_d;

    assign prod  = a * b;
    assign acc_d = (first ? '0 : acc_q) + {{(AW-2*DW){prod[2*DW-1]}}, prod};
    assign res   = DW'(sat_dw(int'(acc_d >>> SHIFT), DW));

    always_ff @(posedge clk) begin
        if (reset)   acc_q <= '0;
        else if (en) acc_q <= acc_d;
    end
endmodule

// File: rtl/nn_layer_mac_engine.sv
// nn_layer_mac_engine: sequential single-layer NN engine, one MAC per cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of nn_layer_mac_engine_if
// Forward: a = ReLU(sat(W*x >>> FRAC)). Optional backprop afterwards: delta,
// error = sat(W^T*delta >>> FRAC) from pre-update weights, then an in-place
// weight update W -= (delta*x^T) >>> (FRAC+LR_SHIFT), one weight per cycle.
module nn_layer_mac_engine
    import nn_pkg::*;
#(
    parameter int N        = 9,
    parameter int DW       = 7,
    parameter int FRAC     = 6,
    parameter int LR_SHIFT = 0
) (
    input logic                  clk,
    input logic                  reset,
    nn_layer_mac_engine_if.slave bus
);
    localparam int             CW   = idx_w(N);
    localparam int             WA   = idx_w(N * N);
    localparam int             AW   = 2 * DW + idx_w(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    logic [2:0]           state;
    logic [CW-1:0]        outer, inner;
    logic signed [DW-1:0] w [N*N];
    logic signed [DW-1:0] x [N];
    logic signed [DW-1:0] z [N];
    logic signed [DW-1:0] delta [N];
    logic signed [DW-1:0] delta_nxt [N];
    logic signed [DW-1:0] e [N];
    logic signed [DW-1:0] in_vec [N];
    logic signed [DW-1:0] w_in;

    // Forward and update walk row-major (outer=row); backprop walks
    // column-major (outer=col) so each column sum finishes on its own.
    logic                   row_major;
    logic [CW-1:0]          row, col;
    logic [WA-1:0]          widx;
    logic signed [DW-1:0]   wcur, mac_b, mac_res, w_upd;
    logic signed [2*DW-1:0] dx;
    logic                   mac_en, row_end, pass_end, acc, hs;

    assign row_major = (state != S_BP_MAC);
    assign row       = row_major ? outer : inner;
    assign col       = row_major ? inner : outer;
    assign widx      = WA'(row) * WA'(N) + WA'(col);
    assign wcur      = w[widx];
    assign mac_b     = row_major ? x[col] : delta[row];
    assign mac_en    = (state == S_FWD_MAC) || (state == S_BP_MAC);
    assign row_end   = (inner == LAST);
    assign pass_end  = row_end && (outer == LAST);
    assign dx        = delta[row] * x[col];
    assign w_upd     = DW'(sat_dw(int'(wcur) - int'(dx >>> (FRAC + LR_SHIFT)), DW));
    assign w_in      = bus.w_data;

    assign bus.in_ready  = (state == S_IDLE) || (state == S_WAIT_BP);
    assign bus.out_valid = (state == S_FWD_OUT) || (state == S_BP_OUT);
    assign bus.out_kind  = (state == S_BP_OUT);
    assign bus.busy      = (state != S_IDLE);
    assign acc           = bus.in_valid && bus.in_ready;
    assign hs            = bus.out_valid && bus.out_ready;

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < N; k++) begin
            in_vec[k] = bus.in_data[DW*k +: DW];
            bus.out_data[DW*k +: DW] = (state == S_BP_OUT) ? e[k] :
                                       (z[k][DW-1] ? '0 : z[k]);
        end
    end

    // z>0 implies a==z, so the target form needs only z.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            delta_nxt[k] = '0;
            if (!z[k][DW-1] && (z[k] != '0))
                delta_nxt[k] = bus.in_last_layer ?
                    DW'(sat_dw(int'(z[k]) - int'(in_vec[k]), DW)) : in_vec[k];
        end
    end

    nn_mac_sat #(.DW(DW), .AW(AW), .SHIFT(FRAC)) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (mac_en),
        .first (inner == '0),
        .a     (wcur),
        .b     (mac_b),
        .res   (mac_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            outer <= '0;
            inner <= '0;
        end else if (mac_en || (state == S_UPDATE)) begin
            if (row_end) begin
                inner <= '0;
                outer <= pass_end ? '0 : outer + 1'b1;
            end else begin
                inner <= inner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            for (int k = 0; k < N; k++) begin
                x[k]     <= '0;
                z[k]     <= '0;
                delta[k] <= '0;
                e[k]     <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    // A backprop request here has no forward context: ack and drop.
                    if (acc && bus.in_mode == MODE_FWD) begin
                        for (int k = 0; k < N; k++) x[k] <= in_vec[k];
                        state <= S_FWD_MAC;
                    end
                end
                S_FWD_MAC: begin
                    if (row_end) z[outer] <= mac_res;
                    if (pass_end) state <= S_FWD_OUT;
                end
                S_FWD_OUT: if (hs) state <= S_WAIT_BP;
                S_WAIT_BP: begin
                    if (acc) begin
                        if (bus.in_mode == MODE_BP) begin
                            for (int k = 0; k < N; k++) delta[k] <= delta_nxt[k];
                            state <= S_BP_MAC;
                        end else begin
                            for (int k = 0; k < N; k++) x[k] <= in_vec[k];
                            state <= S_FWD_MAC;
                        end
                    end
                end
                S_BP_MAC: begin
                    if (row_end) e[outer] <= mac_res;
                    if (pass_end) state <= S_BP_OUT;
                end
                S_BP_OUT: if (hs) state <= S_UPDATE;
                S_UPDATE: if (pass_end) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N*N; k++) w[k] <= '0;
        end else if (state == S_IDLE) begin
            if (bus.w_we && int'(bus.w_addr) < N*N) w[bus.w_addr] <= w_in;
        end else if (state == S_UPDATE) begin
            w[widx] <= w_upd;
        end
    end
endmodule

// File: tb/tb_nn_layer_mac_engine.sv
// Self-checking bench for nn_layer_mac_engine: directed scenarios plus
// randomized forward/backprop rounds against a matrix-level reference model.
module tb_nn_layer_mac_engine;
    localparam int N  = 9;
    localparam int DW = 7;
    localparam int FRAC = 6;
    localparam int LR = 0;
    localparam int VW = N * DW;
    localparam int WA = $clog2(N * N);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    nn_layer_mac_engine_if #(.N(N), .DW(DW)) bus ();

    nn_layer_mac_engine #(.N(N), .DW(DW), .FRAC(FRAC), .LR_SHIFT(LR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int passed = 0;
    int fails = 0;
    int acc_cyc = 0;
    int Wm [N][N];
    int zm [N];
    int xm [N];

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sat(input int v);
        int hi;
        int lo;
        hi = (1 << (DW - 1)) - 1;
        lo = -(1 << (DW - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int el(input logic [VW-1:0] d, input int k);
        logic signed [DW-1:0] t;
        t = d[DW*k +: DW];
        return int'(t);
    endfunction

    function automatic logic [VW-1:0] rep(input int v);
        logic [VW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[DW*k +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[DW*k +: DW] = DW'($urandom_range(0, 127));
        return r;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < N; i++) begin
            zm[i] = 0;
            xm[i] = 0;
            for (int j = 0; j < N; j++) Wm[i][j] = 0;
        end
    endfunction

    function automatic logic [VW-1:0] m_fwd(input logic [VW-1:0] xin);
        logic [VW-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < N; j++) xm[j] = el(xin, j);
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int j = 0; j < N; j++) s += Wm[i][j] * xm[j];
            zm[i] = sat(s >>> FRAC);
            r[DW*i +: DW] = DW'((zm[i] > 0) ? zm[i] : 0);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] m_bp(input logic [VW-1:0] v, input bit last);
        logic [VW-1:0] r;
        int d [N];
        int s;
        r = '0;
        for (int i = 0; i < N; i++)
            d[i] = (zm[i] > 0) ? (last ? sat(zm[i] - el(v, i)) : el(v, i)) : 0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += Wm[i][j] * d[i];
            r[DW*j +: DW] = DW'(sat(s >>> FRAC));
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                Wm[i][j] = sat(Wm[i][j] - ((d[i] * xm[j]) >>> (FRAC + LR)));
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_last_layer = 1'b0;
        bus.in_data = '0; bus.out_ready = 1'b0;
        bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_clear();
    endtask

    task automatic load_w(input int i, input int j, input int v);
        @(negedge clk);
        bus.w_we = 1'b1;
        bus.w_addr = WA'(i * N + j);
        bus.w_data = DW'(v);
        @(posedge clk);
        #1 bus.w_we = 1'b0;
        Wm[i][j] = v;
    endtask

    task automatic send(input bit mode, input bit last, input logic [VW-1:0] data,
                        input bit we, input int wi, input int wj, input int wv);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mode = mode;
        bus.in_last_layer = last;
        bus.in_data = data;
        bus.w_we = we;
        bus.w_addr = WA'(wi * N + wj);
        bus.w_data = DW'(wv);
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_at_send", bus.in_ready, 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc - 1;
        bus.in_valid = 1'b0;
        bus.w_we = 1'b0;
        if (we) Wm[wi][wj] = wv;
    endtask

    task automatic recv(input string tag, input bit kind, input logic [VW-1:0] exp,
                        input int hold, input bit chk_lat);
        int n;
        logic [VW-1:0] held;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, bus.out_valid, 1);
        if (chk_lat) chk({tag, "_latency"}, VW'(cyc - acc_cyc), VW'(N * N + 1));
        chk({tag, "_kind"}, bus.out_kind, kind);
        chk({tag, "_data"}, bus.out_data, exp);
        held = bus.out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, bus.out_valid, 1);
            chk({tag, "_hold_data"}, bus.out_data, held);
            chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] exp;

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_kind", bus.out_kind, 0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_busy", bus.busy, 0);

        // ---- backprop request in IDLE is acked and dropped ----
        send(1'b1, 1'b0, rep(5), 1'b0, 0, 0, 0);
        @(negedge clk);
        chk("idle_bp_drop_busy", bus.busy, 0);

        // ---- identity forward with 10-cycle backpressure ----
        for (int i = 0; i < N; i++) load_w(i, i, 32);
        exp = m_fwd(rep(40));
        send(1'b0, 1'b0, rep(40), 1'b0, 0, 0, 0);
        recv("fwd_identity", 1'b0, exp, 10, 1'b1);
        @(negedge clk);
        chk("after_hs_out_valid", bus.out_valid, 0);
        chk("wait_bp_in_ready", bus.in_ready, 1);
        chk("wait_bp_busy", bus.busy, 1);

        // ---- output-layer backprop, then re-forward through updated weights ----
        exp = m_bp(rep(10), 1'b1);
        send(1'b1, 1'b1, rep(10), 1'b0, 0, 0, 0);
        recv("bp_identity", 1'b1, exp, 0, 1'b0);
        wait_idle("bp_identity");
        exp = m_fwd(rep(40));
        send(1'b0, 1'b0, rep(40), 1'b0, 0, 0, 0);
        recv("refwd", 1'b0, exp, 0, 1'b1);
        // mode=0 while waiting for backprop starts a fresh forward
        v = rnd_vec();
        exp = m_fwd(v);
        send(1'b0, 1'b0, v, 1'b0, 0, 0, 0);
        recv("waitbp_fwd", 1'b0, exp, 0, 1'b1);

        // ---- saturation ----
        do_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) load_w(i, j, 63);
        exp = m_fwd(rep(63));
        send(1'b0, 1'b0, rep(63), 1'b0, 0, 0, 0);
        recv("sat_pos", 1'b0, exp, 0, 1'b0);
        exp = m_fwd(rep(-64));
        send(1'b0, 1'b0, rep(-64), 1'b0, 0, 0, 0);
        recv("sat_neg_relu", 1'b0, exp, 0, 1'b0);

        // ---- gating: zero weights give zero delta, weights untouched ----
        do_reset();
        v = rnd_vec();
        exp = m_fwd(v);
        send(1'b0, 1'b0, v, 1'b0, 0, 0, 0);
        recv("gate_fwd", 1'b0, exp, 0, 1'b0);
        exp = m_bp(rep(10), 1'b1);
        send(1'b1, 1'b1, rep(10), 1'b0, 0, 0, 0);
        recv("gate_err", 1'b1, exp, 0, 1'b0);
        wait_idle("gate");
        load_w(0, 0, 32);
        exp = m_fwd(rep(40));
        send(1'b0, 1'b0, rep(40), 1'b0, 0, 0, 0);
        recv("gate_probe", 1'b0, exp, 0, 1'b0);

        // ---- reset mid-forward ----
        do_reset();
        for (int i = 0; i < N; i++) load_w(i, i, 32);
        send(1'b0, 1'b0, rep(40), 1'b0, 0, 0, 0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_clear();
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        exp = m_fwd(rep(40));
        send(1'b0, 1'b0, rep(40), 1'b0, 0, 0, 0);
        recv("midrst_fwd", 1'b0, exp, 0, 1'b1);

        // ---- randomized rounds ----
        do_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) load_w(i, j, el(rnd_vec(), 0));
        for (int r = 0; r < 4; r++) begin
            int wv;
            v = rnd_vec();
            wv = el(rnd_vec(), 1);
            if (r == 0) begin
                // weight write and accept on the same IDLE cycle
                send(1'b0, 1'b0, v, 1'b1, 1, 1, wv);
                exp = m_fwd(v);
            end else begin
                exp = m_fwd(v);
                send(1'b0, 1'b0, v, 1'b0, 0, 0, 0);
            end
            if (r == 1) begin
                // write strobe outside IDLE must be ignored
                @(negedge clk);
                bus.w_we = 1'b1;
                bus.w_addr = '0;
                bus.w_data = DW'(wv);
                @(negedge clk);
                bus.w_we = 1'b0;
            end
            recv("rnd_fwd", 1'b0, exp, 0, 1'b1);
            v = rnd_vec();
            exp = m_bp(v, r[0]);
            send(1'b1, r[0], v, 1'b0, 0, 0, 0);
            recv("rnd_bp", 1'b1, exp, 0, 1'b0);
            wait_idle("rnd_bp");
        end
        // final forward exposes the accumulated weight updates
        v = rnd_vec();
        exp = m_fwd(v);
        send(1'b0, 1'b0, v, 1'b0, 0, 0, 0);
        recv("rnd_final", 1'b0, exp, 0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
